// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDTH_W = 4;
    localparam int unsigned SUM_W   = ADDR_W + 1;

    localparam logic [WIDTH_W-1:0] WIDTH_BYTE = 4'd1;
    localparam logic [WIDTH_W-1:0] WIDTH_HALF = 4'd2;
    localparam logic [WIDTH_W-1:0] WIDTH_WORD = 4'd4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic               we;
        logic [WIDTH_W-1:0] width;
        logic [DATA_W-1:0]  wdata;
    } mem_req_t;

    // Bad width, or last touched byte past the end; the extra sum bit catches wrap-around.
    function automatic logic access_fault(input logic [ADDR_W-1:0]  addr,
                                          input logic [WIDTH_W-1:0] width,
                                          input int unsigned        depth);
        logic [SUM_W-1:0] last;
        logic             width_ok;
        width_ok = (width == WIDTH_BYTE) || (width == WIDTH_HALF) || (width == WIDTH_WORD);
        last     = SUM_W'(addr) + SUM_W'(width) - SUM_W'(1);
        return !width_ok || (last > SUM_W'(depth - 1));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic with a round-robin priority pointer or fixed port-0 priority.
module rr_arbiter2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_c_o
);

    logic prio_q;

    always_comb begin
        gnt_c_o = 2'b00;
        if (FIXED_PRIORITY) begin
            if (req_i[0])      gnt_c_o = 2'b01;
            else if (req_i[1]) gnt_c_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_c_o = (prio_q == PORT1) ? 2'b10 : 2'b01;
        end else begin
            gnt_c_o = req_i;
        end
    end

    // Priority goes to the port that did not win the last accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PORT0;
        end else if (advance_i && (|gnt_c_o)) begin
            prio_q <= gnt_c_o[0] ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port front end to the single-port data memory: arbitrate, fault-check, access, respond.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_IN_BYTE = 16384,
    parameter bit          FIXED_PRIORITY    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [ADDR_W-1:0]  req0_addr_i,
    input  logic               req0_we_i,
    input  logic [WIDTH_W-1:0] req0_width_i,
    input  logic [DATA_W-1:0]  req0_wdata_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [ADDR_W-1:0]  req1_addr_i,
    input  logic               req1_we_i,
    input  logic [WIDTH_W-1:0] req1_width_i,
    input  logic [DATA_W-1:0]  req1_wdata_i,
    output logic               rsp0_valid_o,
    output logic [DATA_W-1:0]  rsp0_rdata_o,
    output logic               rsp0_err_o,
    output logic               rsp1_valid_o,
    output logic [DATA_W-1:0]  rsp1_rdata_o,
    output logic               rsp1_err_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_write_enable_o,
    output logic [WIDTH_W-1:0] mem_write_width_o,
    output logic [DATA_W-1:0]  mem_write_data_o,
    input  logic [DATA_W-1:0]  mem_read_data_i
);

    state_e            state_q, state_d;
    mem_req_t          req_q, sel_req_c;
    logic              port_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [1:0]        gnt_c;
    logic              accept_c;

    rr_arbiter2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid_i, req0_valid_i}),
        .advance_i(accept_c),
        .gnt_c_o  (gnt_c)
    );

    assign accept_c = (state_q == ST_IDLE) && (|gnt_c);

    always_comb begin
        if (gnt_c[1]) begin
            sel_req_c.addr  = req1_addr_i;
            sel_req_c.we    = req1_we_i;
            sel_req_c.width = req1_width_i;
            sel_req_c.wdata = req1_wdata_i;
        end else begin
            sel_req_c.addr  = req0_addr_i;
            sel_req_c.we    = req0_we_i;
            sel_req_c.width = req0_width_i;
            sel_req_c.wdata = req0_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            port_q   <= PORT0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                req_q  <= sel_req_c;
                port_q <= gnt_c[1] ? PORT1 : PORT0;
                err_q  <= access_fault(sel_req_c.addr, sel_req_c.width, MEM_DEPTH_IN_BYTE);
            end
            // Faulted accesses return zero instead of whatever the memory drives.
            if (state_q == ST_ACCESS) begin
                if (port_q == PORT0) rdata0_q <= err_q ? '0 : mem_read_data_i;
                else                 rdata1_q <= err_q ? '0 : mem_read_data_i;
            end
        end
    end

    assign rsp0_rdata_o = rdata0_q;
    assign rsp1_rdata_o = rdata1_q;

    always_comb begin
        state_d            = state_q;
        req0_ready_o       = 1'b0;
        req1_ready_o       = 1'b0;
        rsp0_valid_o       = 1'b0;
        rsp0_err_o         = 1'b0;
        rsp1_valid_o       = 1'b0;
        rsp1_err_o         = 1'b0;
        mem_addr_o         = '0;
        mem_write_enable_o = 1'b0;
        mem_write_width_o  = '0;
        mem_write_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                req0_ready_o = gnt_c[0];
                req1_ready_o = gnt_c[1];
                if (|gnt_c) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_addr_o         = req_q.addr;
                mem_write_enable_o = req_q.we & ~err_q;
                mem_write_width_o  = req_q.width;
                mem_write_data_o   = req_q.wdata;
                state_d            = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid_o = (port_q == PORT0);
                rsp0_err_o   = (port_q == PORT0) && err_q;
                rsp1_valid_o = (port_q == PORT1);
                rsp1_err_o   = (port_q == PORT1) && err_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
